decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/core_pkg.sv | 47 ++++
 rtl/decode_fields.sv | 163 ++++++++++++++++
 rtl/decode_stage.sv | 94 +++++++++
 tb/tb_decode_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode constants: opcodes, ALU operation codes and the control-bundle layout.
package core_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  localparam logic [4:0] ALU_AND      = 5'd0;
  localparam logic [4:0] ALU_OR       = 5'd1;
  localparam logic [4:0] ALU_ADD      = 5'd2;
  localparam logic [4:0] ALU_XOR      = 5'd3;
  localparam logic [4:0] ALU_SLL      = 5'd4;
  localparam logic [4:0] ALU_SRL      = 5'd5;
  localparam logic [4:0] ALU_SUB      = 5'd6;
  localparam logic [4:0] ALU_LT       = 5'd7;
  localparam logic [4:0] ALU_GE       = 5'd8;
  localparam logic [4:0] ALU_CHOOSEB  = 5'd10;
  localparam logic [4:0] ALU_EQ       = 5'd11;
  localparam logic [4:0] ALU_NE       = 5'd12;
  localparam logic [4:0] ALU_LTU      = 5'd13;
  localparam logic [4:0] ALU_GEU      = 5'd14;
  localparam logic [4:0] ALU_SRA      = 5'd15;
  localparam logic [4:0] ALU_MUL_BASE = 5'd16;
  localparam logic [4:0] ALU_ZERO     = 5'd31;

  // Field order fixes the bit positions of out_ctl, reg_write at bit 8 down to illegal at bit 0.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic pc_src_a;
    logic branch_c;
    logic branch_uc;
    logic branch_relative;
    logic illegal;
  } ctl_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32/RV64 field decode: immediate, ALU op, register indices, control bundle.
module decode_fields
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int EN_M   = 0
) (
  input  logic [31:0]       instr,
  output logic [XLEN-1:0]   imm,
  output logic [4:0]        alu_ctl,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output ctl_t              ctl,
  output logic [2:0]        mem_size
);

  localparam bit RV64 = (XLEN == 64);

  opcode_e           opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic signed [31:0] imm32;
  logic              shamt_ok;

  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  assign rs1 = REG_AW'(instr[19:15]);
  assign rs2 = REG_AW'(instr[24:20]);
  assign rd  = REG_AW'(instr[11:7]);
  assign imm = sext(imm32);

  always_comb begin
    opc      = opcode_e'(instr[6:0]);
    f3       = instr[14:12];
    f7       = instr[31:25];
    shamt_ok = RV64 ? 1'b1 : !instr[25];
    imm32    = '0;
    alu_ctl  = ALU_ZERO;
    ctl      = '0;
    mem_size = '0;
    case (opc)
      OPC_LUI: begin
        imm32 = {instr[31:12], 12'b0};
        alu_ctl = ALU_CHOOSEB;
        ctl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm32 = {instr[31:12], 12'b0};
        alu_ctl = ALU_ADD;
        ctl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        alu_ctl = ALU_CHOOSEB;
        ctl.reg_write = 1'b1;
        ctl.branch_uc = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        alu_ctl = ALU_ADD;
        ctl.reg_write = 1'b1;
        ctl.branch_uc = 1'b1;
        ctl.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        ctl.branch_c = 1'b1;
        case (f3)
          3'b000:  alu_ctl = ALU_EQ;
          3'b001:  alu_ctl = ALU_NE;
          3'b100:  alu_ctl = ALU_LT;
          3'b101:  alu_ctl = ALU_GE;
          3'b110:  alu_ctl = ALU_LTU;
          3'b111:  alu_ctl = ALU_GEU;
          default: ctl.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        alu_ctl = ALU_ADD;
        ctl.reg_write = 1'b1;
        ctl.mem_read = 1'b1;
        mem_size = f3;
        ctl.illegal = !((f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                        (RV64 && (f3 inside {3'd3, 3'd6})));
      end
      OPC_STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        alu_ctl = ALU_ADD;
        ctl.mem_write = 1'b1;
        mem_size = f3;
        ctl.illegal = !((f3 <= 3'd2) || (RV64 && (f3 == 3'd3)));
      end
      OPC_OP_IMM: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        ctl.reg_write = 1'b1;
        case (f3)
          3'b000: alu_ctl = ALU_ADD;
          3'b010: alu_ctl = ALU_LT;
          3'b011: alu_ctl = ALU_LTU;
          3'b100: alu_ctl = ALU_XOR;
          3'b110: alu_ctl = ALU_OR;
          3'b111: alu_ctl = ALU_AND;
          3'b001: begin
            alu_ctl = ALU_SLL;
            ctl.illegal = (instr[31:26] != 6'b0) || !shamt_ok;
          end
          default: begin
            alu_ctl = instr[30] ? ALU_SRA : ALU_SRL;
            ctl.illegal = instr[31] || (instr[29:26] != 4'b0) || !shamt_ok;
          end
        endcase
      end
      OPC_OP: begin
        ctl.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  alu_ctl = ALU_ADD;
            3'b001:  alu_ctl = ALU_SLL;
            3'b010:  alu_ctl = ALU_LT;
            3'b011:  alu_ctl = ALU_LTU;
            3'b100:  alu_ctl = ALU_XOR;
            3'b101:  alu_ctl = ALU_SRL;
            3'b110:  alu_ctl = ALU_OR;
            default: alu_ctl = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          alu_ctl = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          alu_ctl = ALU_SRA;
        end else if (f7 == 7'b0000001 && EN_M != 0) begin
          alu_ctl = ALU_MUL_BASE + {2'b00, f3};
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      default: ctl.illegal = 1'b1;
    endcase

    // Compressed encodings are not supported, so anything without 2'b11 in the low bits traps.
    if (instr[1:0] != 2'b11) ctl.illegal = 1'b1;

    ctl.alu_src         = !(opc == OPC_OP || opc == OPC_BRANCH);
    ctl.pc_src_a        = (opc == OPC_AUIPC);
    ctl.branch_relative = (opc != OPC_JALR);

    if (ctl.illegal) begin
      alu_ctl       = ALU_ZERO;
      ctl.reg_write = 1'b0;
      ctl.mem_read  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.branch_c  = 1'b0;
      ctl.branch_uc = 1'b0;
      mem_size      = '0;
    end
    if (instr[11:7] == 5'd0) ctl.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-entry valid/ready register around the combinational field decoder.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int EN_M   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_alu_ctl,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [8:0]        out_ctl,
  output logic [2:0]        out_mem_size
);

  logic [XLEN-1:0]   dec_imm;
  logic [4:0]        dec_alu;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  ctl_t              dec_ctl;
  logic [2:0]        dec_msize;

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1, imm_p1;
  logic [4:0]        alu_p1;
  logic [REG_AW-1:0] rs1_p1, rs2_p1, rd_p1;
  ctl_t              ctl_p1;
  logic [2:0]        msize_p1;

  decode_fields #(.XLEN(XLEN), .REG_AW(REG_AW), .EN_M(EN_M)) u_fields (
    .instr    (in_instr),
    .imm      (dec_imm),
    .alu_ctl  (dec_alu),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .ctl      (dec_ctl),
    .mem_size (dec_msize)
  );

  // Reset and flush keep the port open; whatever fetch offers in those cycles is dropped.
  assign in_ready = rst || flush || !vld_p1 || out_ready;

  // Stage boundary: decoded bundle registered into _p1, presented to execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      imm_p1   <= '0;
      alu_p1   <= ALU_ZERO;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rd_p1    <= '0;
      ctl_p1   <= '0;
      msize_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1   <= 1'b1;
      pc_p1    <= in_pc;
      imm_p1   <= dec_imm;
      alu_p1   <= dec_alu;
      rs1_p1   <= dec_rs1;
      rs2_p1   <= dec_rs2;
      rd_p1    <= dec_rd;
      ctl_p1   <= dec_ctl;
      msize_p1 <= dec_msize;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_pc       = pc_p1;
  assign out_imm      = imm_p1;
  assign out_alu_ctl  = alu_p1;
  assign out_rs1      = rs1_p1;
  assign out_rs2      = rs2_p1;
  assign out_rd       = rd_p1;
  assign out_ctl      = ctl_p1;
  assign out_mem_size = msize_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus stall, flush and reset sequences.
module tb_decode_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;

  logic              in_ready, out_valid;
  logic [XLEN-1:0]   out_pc, out_imm;
  logic [4:0]        out_alu_ctl;
  logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
  logic [8:0]        out_ctl;
  logic [2:0]        out_mem_size;

  logic              in_ready_m, out_valid_m;
  logic [XLEN-1:0]   out_pc_m, out_imm_m;
  logic [4:0]        out_alu_ctl_m;
  logic [REG_AW-1:0] out_rs1_m, out_rs2_m, out_rd_m;
  logic [8:0]        out_ctl_m;
  logic [2:0]        out_mem_size_m;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .EN_M(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_alu_ctl(out_alu_ctl), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_ctl(out_ctl), .out_mem_size(out_mem_size)
  );

  decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .EN_M(1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_pc(out_pc_m), .out_imm(out_imm_m), .out_alu_ctl(out_alu_ctl_m), .out_rs1(out_rs1_m),
    .out_rs2(out_rs2_m), .out_rd(out_rd_m), .out_ctl(out_ctl_m), .out_mem_size(out_mem_size_m)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [8:0]  ctl;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  msize;
    logic [4:0]  alu_m;
    logic [8:0]  ctl_m;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] imm, logic [4:0] alu,
                              logic [8:0] ctl, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [2:0] msize);
    vec_t v;
    v.name = name; v.instr = instr; v.imm = imm; v.alu = alu; v.ctl = ctl;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.msize = msize;
    v.alu_m = alu; v.ctl_m = ctl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input logic [31:0] pc);
    check({v.name, ".valid"}, 64'(out_valid), 64'd1);
    check({v.name, ".pc"}, 64'(out_pc), 64'(pc));
    check({v.name, ".imm"}, 64'(out_imm), 64'(v.imm));
    check({v.name, ".alu"}, 64'(out_alu_ctl), 64'(v.alu));
    check({v.name, ".ctl"}, 64'(out_ctl), 64'(v.ctl));
    check({v.name, ".rs1"}, 64'(out_rs1), 64'(v.rs1));
    check({v.name, ".rs2"}, 64'(out_rs2), 64'(v.rs2));
    check({v.name, ".rd"}, 64'(out_rd), 64'(v.rd));
    check({v.name, ".msize"}, 64'(out_mem_size), 64'(v.msize));
    check({v.name, ".m_alu"}, 64'(out_alu_ctl_m), 64'(v.alu_m));
    check({v.name, ".m_ctl"}, 64'(out_ctl_m), 64'(v.ctl_m));
  endtask

  initial begin
    vec_t v;
    vecs.push_back(mk("addi",   32'h00500093, 32'h00000005, 5'd2,  9'h122, 5'd0,  5'd5,  5'd1,  3'd0));
    vecs.push_back(mk("beq",    32'hFE208EE3, 32'hFFFFFFFC, 5'd11, 9'h00A, 5'd1,  5'd2,  5'd29, 3'd0));
    v = mk("mul", 32'h022081B3, 32'h0, 5'd31, 9'h003, 5'd1, 5'd2, 5'd3, 3'd0);
    v.alu_m = 5'd16; v.ctl_m = 9'h102;
    vecs.push_back(v);
    vecs.push_back(mk("nop",    32'h00000013, 32'h00000000, 5'd2,  9'h022, 5'd0,  5'd0,  5'd0,  3'd0));
    vecs.push_back(mk("custom", 32'h0000000B, 32'h00000000, 5'd31, 9'h023, 5'd0,  5'd0,  5'd0,  3'd0));
    vecs.push_back(mk("lui",    32'h123452B7, 32'h12345000, 5'd10, 9'h122, 5'd8,  5'd3,  5'd5,  3'd0));
    vecs.push_back(mk("auipc",  32'hFFFFF117, 32'hFFFFF000, 5'd2,  9'h132, 5'd31, 5'd31, 5'd2,  3'd0));
    vecs.push_back(mk("sw",     32'h0020A423, 32'h00000008, 5'd2,  9'h062, 5'd1,  5'd2,  5'd8,  3'd2));
    vecs.push_back(mk("lw",     32'hFFC0A183, 32'hFFFFFFFC, 5'd2,  9'h1A2, 5'd1,  5'd28, 5'd3,  3'd2));
    vecs.push_back(mk("jal",    32'h008000EF, 32'h00000008, 5'd10, 9'h126, 5'd0,  5'd8,  5'd1,  3'd0));
    vecs.push_back(mk("ret",    32'h00008067, 32'h00000000, 5'd2,  9'h024, 5'd1,  5'd0,  5'd0,  3'd0));
    vecs.push_back(mk("srai",   32'h40335293, 32'h00000403, 5'd15, 9'h122, 5'd6,  5'd3,  5'd5,  3'd0));
    vecs.push_back(mk("slli32", 32'h02009093, 32'h00000020, 5'd31, 9'h023, 5'd1,  5'd0,  5'd1,  3'd0));
    vecs.push_back(mk("sub",    32'h402081B3, 32'h00000000, 5'd6,  9'h102, 5'd1,  5'd2,  5'd3,  3'd0));
    vecs.push_back(mk("rvc",    32'h00500091, 32'h00000000, 5'd31, 9'h023, 5'd0,  5'd5,  5'd1,  3'd0));
    vecs.push_back(mk("badbr",  32'hFE20AEE3, 32'hFFFFFFFC, 5'd31, 9'h003, 5'd1,  5'd2,  5'd29, 3'd0));

    // Reset with traffic and flush present: reset wins, port stays ready.
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h00500093; in_pc = 32'h44;
    @(posedge clk); #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.pc", 64'(out_pc), 64'd0);
    check("rst.imm", 64'(out_imm), 64'd0);
    check("rst.alu", 64'(out_alu_ctl), 64'd31);
    check("rst.regs", 64'({out_rs1, out_rs2, out_rd}), 64'd0);
    check("rst.ctl", 64'(out_ctl), 64'd0);
    check("rst.msize", 64'(out_mem_size), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.valid", 64'(out_valid), 64'd0);
    check("idle.in_ready", 64'(in_ready), 64'd1);

    // Back-to-back table, consumer always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      @(posedge clk); #1;
      check_vec(vecs[i], 32'h1000 + 32'(4 * i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain.valid", 64'(out_valid), 64'd0);

    // Stall three cycles with the next instruction waiting.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h2000;
    @(posedge clk); #1;
    check("stall.load_valid", 64'(out_valid), 64'd1);
    check("stall.load_pc", 64'(out_pc), 64'h2000);
    in_instr = 32'h402081B3; in_pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("stall.hold_valid", 64'(out_valid), 64'd1);
      check("stall.hold_pc", 64'(out_pc), 64'h2000);
      check("stall.hold_alu", 64'(out_alu_ctl), 64'd2);
      check("stall.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; #1;
    check("stall.release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("stall.next_valid", 64'(out_valid), 64'd1);
    check("stall.next_pc", 64'(out_pc), 64'h2004);
    check("stall.next_alu", 64'(out_alu_ctl), 64'd6);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stall.no_dup", 64'(out_valid), 64'd0);

    // Flush with a held bundle and a new offer: both discarded.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h3000;
    @(posedge clk); #1;
    check("flush.pre_valid", 64'(out_valid), 64'd1);
    in_instr = 32'h402081B3; in_pc = 32'h3004; flush = 1'b1; #1;
    check("flush.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.not_captured", 64'(out_pc), 64'h3000);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush.after", 64'(out_valid), 64'd0);

    // Reset in mid-stream loses the held bundle.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h4000;
    @(posedge clk); #1;
    check("midrst.pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; #1;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("midrst.valid", 64'(out_valid), 64'd0);
    check("midrst.pc", 64'(out_pc), 64'd0);
    check("midrst.alu", 64'(out_alu_ctl), 64'd31);
    check("midrst.ctl", 64'(out_ctl), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
